// File: rtl/epmp_defs.sv
// Shared EPMP definitions: fetch FSM state encoding and the default wait-state
// timeout used by the two-byte memory fetch engine.
package epmp_defs;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_HI = 3'd1,
        ST_LD_HI = 3'd2,
        ST_RD_LO = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_e;

    localparam int unsigned EPMP_TIMEOUT_CYC_DEF = 15;

endpackage

// File: rtl/epmp_mem_fetch.sv
// Two-byte memory fetch: reads addr (high byte, loaded into the aux register)
// then addr+1 (low byte). Optional wait-state timeout with EPMP_FETCH_TIMEOUT_EN.
module epmp_mem_fetch
    import epmp_defs::*;
#(
    parameter int unsigned TIMEOUT_CYC = EPMP_TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [7:0]  mem_d,
    input  logic        mem_rdy,
    output logic [15:0] mem_a,
    output logic        mem_rd_n,
    output logic        AuxR_Load_En,
    output logic [7:0]  D,
    output logic [7:0]  lo_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout_cyc
        $error("epmp_mem_fetch: TIMEOUT_CYC must be within 1..255");
    end

    fetch_state_e state_q, state_d;
    logic [15:0]  addr_q, addr_d;
    logic [15:0]  mem_a_q, mem_a_d;
    logic [7:0]   d_q, d_d;
    logic [7:0]   lo_q, lo_d;
    logic         rd_phase;
    logic         timeout_hit;

    assign rd_phase = (state_q == ST_RD_HI) || (state_q == ST_RD_LO);

`ifdef EPMP_FETCH_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // The cycle that would make the count reach TIMEOUT_CYC is the timeout cycle itself.
    assign timeout_hit = rd_phase && !mem_rdy && (wait_cnt_q == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        wait_cnt_d = 8'd0;
        if (rd_phase && !mem_rdy && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 16'h0000;
            mem_a_q <= 16'h0000;
            d_q     <= 8'h00;
            lo_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mem_a_q <= mem_a_d;
            d_q     <= d_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        d_d     = d_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    state_d = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                if (mem_rdy) begin
                    d_d     = mem_d;
                    state_d = ST_LD_HI;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LD_HI: state_d = ST_RD_LO;
            ST_RD_LO: begin
                if (mem_rdy) begin
                    lo_d    = mem_d;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outside the read states the bus keeps whatever address was last driven.
    always_comb begin
        mem_a_d = mem_a_q;
        case (state_q)
            ST_RD_HI: mem_a_d = addr_q;
            ST_RD_LO: mem_a_d = addr_q + 16'h0001;
            default:  mem_a_d = mem_a_q;
        endcase
        mem_a        = mem_a_d;
        mem_rd_n     = !rd_phase || timeout_hit;
        AuxR_Load_En = (state_q == ST_LD_HI);
        done         = (state_q == ST_DONE);
        busy         = (state_q != ST_IDLE);
        err          = timeout_hit;
    end

    assign D       = d_q;
    assign lo_data = lo_q;

endmodule
